data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Multi-cycle data-memory slave that services the CPU's load/store requests from the memory stage over a valid/ready request channel and a one-cycle response pulse. It implements byte/half/word access with optional sign extension, using the same width and sign-extend semantics the CPU's control decodes. It flags misaligned, illegal-width and out-of-range requests, and it replaces the zero-latency data memory so the pipeline can be exercised against realistic memory latency.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in storage; addressable range is 0 .. DEPTH_WORDS*4-1.
LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  1  request present
req_ready_o  out  1  responder can accept a request this cycle
req_write_i  in  1  1 = store, 0 = load
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_width_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_sign_extend_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend
resp_valid_o  out  1  one-cycle response pulse
resp_rdata_o  out  32  load result, extended to 32 bits; 0 for stores and errors
resp_err_o  out  1  qualified by resp_valid_o; misaligned, illegal width, or out of range

Behaviour:
- Reset (rst_i high at an edge):
  - FSM goes to IDLE; req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0; latency counter = 0.
  - Any in-flight request is dropped: a store not yet committed is never written, and no response is produced.
  - Storage contents are not reset.
- Acceptance: a request is accepted in any cycle where req_valid_i && req_ready_o. All request fields are captured at that edge. Inputs are don't-care in other cycles.
- FSM IDLE:
  - req_ready_o=1.
  - On acceptance: go to WAIT with counter = LATENCY-1 if LATENCY>1; go straight to RESP if LATENCY=1.
- FSM WAIT:
  - req_ready_o=0.
  - Counter decrements each cycle; when counter==1 the next state is RESP.
- FSM RESP:
  - resp_valid_o=1 for exactly this one cycle; resp_rdata_o/resp_err_o valid only here.
  - req_ready_o=1; a request accepted in this cycle re-enters WAIT/RESP exactly as from IDLE. Otherwise go to IDLE.
  - There is no response backpressure.
- Latency: if accepted in cycle k, resp_valid_o is high in cycle k+LATENCY. Sustained throughput is one request per LATENCY cycles.
- Commit point: on the edge entering RESP, a store writes storage and a load reads storage; both use the captured fields. A load accepted in the RESP cycle of a store therefore sees that store's data.
- Error rules (err=1 means no write, rdata=0):
  - width==3;
  - width==1 with addr[0]=1;
  - width==2 with addr[1:0]!=0;
  - addr >= DEPTH_WORDS*4.
- Store lane rules (little-endian; unaffected lanes preserved):
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes addr[1]*2 .. +1 get wdata[15:0].
  - word: full word.
- Load extraction:
  - Select the same lane(s) as for stores and right-align.
  - Extend from bit 7 (byte) or bit 15 (half) when req_sign_extend_i=1, else zero-extend.
  - req_sign_extend_i is ignored for word loads.
- Word index = addr[ADDR_W+1:2], where ADDR_W = clog2(DEPTH_WORDS).

Decomposition:
- Shared package:
  - width encoding constants: WIDTH_BYTE=0, WIDTH_HALF=1, WIDTH_WORD=2;
  - FSM state enum {IDLE, WAIT, RESP};
  - the illegal-width constant.
- One combinational sub-module, data_mem_lane:
  - inputs: addr[1:0], width, sign_extend, old word, wdata;
  - outputs: merged store word, extracted/extended load value, misalign flag.
- The FSM, counter, storage array and range check stay in the top.

Test Plan:
- Store/load round trip (LATENCY=2): SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
- Byte sign and zero extension: SB addr 0x21 data 0x000000F0 over word 0x11223344 -> word reads 0x1122F044. LB 0x21 -> 0xFFFFFFF0; LBU 0x21 -> 0x000000F0.
- Half-word zero extension: SH addr 0x32 data 0x8001, then LHU 0x32 -> 0x00008001; LH 0x32 -> 0xFFFF8001.
- Error responses: LW 0x13 -> err 1, rdata 0. SH 0x05 -> err 1, and a following LW 0x04 shows the word unchanged. LW addr 0x1000 with DEPTH_WORDS=1024 -> err 1. width=3 -> err 1.
- Back-to-back throughput: hold req_valid high for 4 loads -> accepts spaced exactly LATENCY cycles apart. The request accepted in the RESP cycle of a prior SW 0x40=0x5A5A5A5A reads 0x5A5A5A5A.
- Mid-operation reset: accept SW 0x50=0x12345678 (old value 0), assert rst_i in the WAIT cycle -> no resp_valid, ready=1 the next cycle. A subsequent LW 0x50 returns 0.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access widths and FSM states.
package data_mem_responder_pkg;

   localparam logic [1:0] WIDTH_BYTE    = 2'd0;
   localparam logic [1:0] WIDTH_HALF    = 2'd1;
   localparam logic [1:0] WIDTH_WORD    = 2'd2;
   localparam logic [1:0] WIDTH_ILLEGAL = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/data_mem_lane.sv
// Little-endian lane steering: store merge, load extract/extend, misalignment.
module data_mem_lane
   import data_mem_responder_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [1:0]  width,
   input  logic        sign_extend,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] merged_word_c,
   output logic [31:0] load_data_c,
   output logic        misalign_c
);

   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // Select lanes by width; illegal width leaves the word untouched.
   always_comb begin
      merged_word_c = old_word;
      load_data_c   = '0;
      misalign_c    = 1'b0;
      byte_sh       = {offset, 3'b000};
      half_sh       = {offset[1], 4'b0000};
      byte_val      = old_word[byte_sh +: 8];
      half_val      = old_word[half_sh +: 16];
      case (width)
         WIDTH_BYTE: begin
            merged_word_c[byte_sh +: 8] = wdata[7:0];
            load_data_c = sign_extend ? {{24{byte_val[7]}}, byte_val}
                                      : {24'd0, byte_val};
         end
         WIDTH_HALF: begin
            misalign_c = offset[0];
            merged_word_c[half_sh +: 16] = wdata[15:0];
            load_data_c = sign_extend ? {{16{half_val[15]}}, half_val}
                                      : {16'd0, half_val};
         end
         WIDTH_WORD: begin
            misalign_c    = (offset != 2'd0);
            merged_word_c = wdata;
            load_data_c   = old_word;
         end
         default: begin
            merged_word_c = old_word;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave with fixed latency and error reporting.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [1:0]  req_width_i,
   input  logic        req_sign_extend_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o
);

   localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W      = 4;
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

   state_t             state;
   logic [CNT_W-1:0]   cnt;

   logic               cap_write;
   logic [31:0]        cap_addr;
   logic [31:0]        cap_wdata;
   logic [1:0]         cap_width;
   logic               cap_sext;

   logic [31:0]        mem [DEPTH_WORDS];

   logic               accept_c;
   logic               commit_c;
   logic               com_write_c;
   logic [31:0]        com_addr_c;
   logic [31:0]        com_wdata_c;
   logic [1:0]         com_width_c;
   logic               com_sext_c;
   logic [ADDR_W-1:0]  word_idx_c;
   logic               in_range_c;
   logic [31:0]        old_word_c;
   logic [31:0]        merged_c;
   logic [31:0]        load_c;
   logic               misalign_c;
   logic               err_c;

   // With single-cycle latency the commit happens on the accept edge itself.
   always_comb begin
      accept_c    = req_valid_i && req_ready_o;
      commit_c    = ((state == WAIT) && (cnt == CNT_W'(1)))
                 || (accept_c && (LATENCY == 1));
      com_write_c = (LATENCY == 1) ? req_write_i       : cap_write;
      com_addr_c  = (LATENCY == 1) ? req_addr_i        : cap_addr;
      com_wdata_c = (LATENCY == 1) ? req_wdata_i       : cap_wdata;
      com_width_c = (LATENCY == 1) ? req_width_i       : cap_width;
      com_sext_c  = (LATENCY == 1) ? req_sign_extend_i : cap_sext;
      word_idx_c  = com_addr_c[ADDR_W+1:2];
      in_range_c  = (com_addr_c < ADDR_LIMIT);
      old_word_c  = in_range_c ? mem[word_idx_c] : '0;
      err_c       = (com_width_c == WIDTH_ILLEGAL) || misalign_c || !in_range_c;
   end

   data_mem_lane u_lane (
      .offset        (com_addr_c[1:0]),
      .width         (com_width_c),
      .sign_extend   (com_sext_c),
      .old_word      (old_word_c),
      .wdata         (com_wdata_c),
      .merged_word_c (merged_c),
      .load_data_c   (load_c),
      .misalign_c    (misalign_c)
   );

   // Request FSM, latency counter and registered response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         cnt          <= '0;
         req_ready_o  <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
         cap_write    <= 1'b0;
         cap_addr     <= '0;
         cap_wdata    <= '0;
         cap_width    <= WIDTH_BYTE;
         cap_sext     <= 1'b0;
      end else begin
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (accept_c) begin
                  cap_write <= req_write_i;
                  cap_addr  <= req_addr_i;
                  cap_wdata <= req_wdata_i;
                  cap_width <= req_width_i;
                  cap_sext  <= req_sign_extend_i;
                  if (LATENCY > 1) begin
                     state       <= WAIT;
                     cnt         <= CNT_W'(LATENCY - 1);
                     req_ready_o <= 1'b0;
                  end else begin
                     state       <= RESP;
                     req_ready_o <= 1'b1;
                  end
               end else begin
                  state       <= IDLE;
                  req_ready_o <= 1'b1;
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state       <= RESP;
                  req_ready_o <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               req_ready_o <= 1'b1;
            end
         endcase
         if (commit_c) begin
            resp_valid_o <= 1'b1;
            resp_rdata_o <= (com_write_c || err_c) ? 32'd0 : load_c;
            resp_err_o   <= err_c;
         end
      end
   end

   // Storage write at the commit edge; reset drops an uncommitted store.
   always_ff @(posedge clk_i) begin
      if (!rst_i && commit_c && com_write_c && !err_c) begin
         mem[word_idx_c] <= merged_c;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_data_mem_responder;

   localparam int unsigned LAT    = 2;
   localparam int unsigned DEPTH  = 1024;
   localparam time         PERIOD = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_width = 2'd0;
   logic        req_sext = 1'b0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      time         due;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   time  t_acc [0:4];

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .req_valid_i       (req_valid),
      .req_ready_o       (req_ready),
      .req_write_i       (req_write),
      .req_addr_i        (req_addr),
      .req_wdata_i       (req_wdata),
      .req_width_i       (req_width),
      .req_sign_extend_i (req_sext),
      .resp_valid_o      (resp_valid),
      .resp_rdata_o      (resp_rdata),
      .resp_err_o        (resp_err)
   );

   always #(PERIOD/2) clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Monitor: every response pulse is matched against the next expectation.
   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: got rdata %08h err %0b expected no response",
                     resp_rdata, resp_err);
         end else begin
            mon_e = sb.pop_front();
            check32({mon_e.name, "_rdata"}, resp_rdata, mon_e.rdata);
            check32({mon_e.name, "_err"}, 32'(resp_err), 32'(mon_e.err));
            tests++;
            if ($time != mon_e.due) begin
               fails++;
               $display("FAIL %s_latency: got t=%0t expected t=%0t", mon_e.name, $time, mon_e.due);
            end
         end
      end
   end

   // Present a request and hold it until accepted; optionally queue its response.
   task automatic issue(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] width, input logic sext,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input bit expect_resp, output time acc);
      bit ok = 1'b0;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_width = width;
      req_sext  = sext;
      req_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk);
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL %s_accept: got no acceptance expected acceptance within 50 cycles", name);
      end else begin
         acc = $time;
         if (expect_resp)
            sb.push_back('{exp_rdata, exp_err, $time + (LAT - 1) * PERIOD + PERIOD / 2, name});
      end
      #1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending responses expected 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic op(input string name, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] width, input logic sext,
                     input logic [31:0] exp_rdata, input logic exp_err);
      time t;
      issue(name, wr, addr, wdata, width, sext, exp_rdata, exp_err, 1'b1, t);
      idle();
      drain();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check32("reset_ready", 32'(req_ready), 32'd1);
      check32("reset_valid", 32'(resp_valid), 32'd0);
      check32("reset_rdata", resp_rdata, 32'd0);
      check32("reset_err", 32'(resp_err), 32'd0);
      @(posedge clk);
      #1;

      // Word round trip
      op("sw_10", 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 32'h0, 0);
      op("lw_10", 0, 32'h10, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0);

      // Byte merge and extension
      op("sw_20", 1, 32'h20, 32'h11223344, 2'd2, 0, 32'h0, 0);
      op("sb_21", 1, 32'h21, 32'h000000F0, 2'd0, 0, 32'h0, 0);
      op("lw_20", 0, 32'h20, 32'h0, 2'd2, 1, 32'h1122F044, 0);
      op("lb_21", 0, 32'h21, 32'h0, 2'd0, 1, 32'hFFFFFFF0, 0);
      op("lbu_21", 0, 32'h21, 32'h0, 2'd0, 0, 32'h000000F0, 0);

      // Half-word extension
      op("sw_30", 1, 32'h30, 32'h0, 2'd2, 0, 32'h0, 0);
      op("sh_32", 1, 32'h32, 32'hFFFF8001, 2'd1, 0, 32'h0, 0);
      op("lhu_32", 0, 32'h32, 32'h0, 2'd1, 0, 32'h00008001, 0);
      op("lh_32", 0, 32'h32, 32'h0, 2'd1, 1, 32'hFFFF8001, 0);
      op("lw_30", 0, 32'h30, 32'h0, 2'd2, 0, 32'h80010000, 0);

      // Errors and range boundary
      op("lw_13_mis", 0, 32'h13, 32'h0, 2'd2, 0, 32'h0, 1);
      op("sw_04", 1, 32'h04, 32'hCAFEF00D, 2'd2, 0, 32'h0, 0);
      op("sh_05_mis", 1, 32'h05, 32'h0000BEEF, 2'd1, 0, 32'h0, 1);
      op("lw_04", 0, 32'h04, 32'h0, 2'd2, 0, 32'hCAFEF00D, 0);
      op("lw_1000_oor", 0, 32'h1000, 32'h0, 2'd2, 0, 32'h0, 1);
      op("w3_illegal", 0, 32'h10, 32'h0, 2'd3, 0, 32'h0, 1);
      op("sw_ffc", 1, 32'hFFC, 32'h0BADC0DE, 2'd2, 0, 32'h0, 0);
      op("lw_ffc", 0, 32'hFFC, 32'h0, 2'd2, 0, 32'h0BADC0DE, 0);

      // Back-to-back: valid held, first load lands in the store's RESP cycle
      issue("b2b_sw_40", 1, 32'h40, 32'h5A5A5A5A, 2'd2, 0, 32'h0, 0, 1'b1, t_acc[0]);
      issue("b2b_lw_40", 0, 32'h40, 32'h0, 2'd2, 0, 32'h5A5A5A5A, 0, 1'b1, t_acc[1]);
      issue("b2b_lw_10", 0, 32'h10, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0, 1'b1, t_acc[2]);
      issue("b2b_lb_21", 0, 32'h21, 32'h0, 2'd0, 1, 32'hFFFFFFF0, 0, 1'b1, t_acc[3]);
      issue("b2b_lhu_32", 0, 32'h32, 32'h0, 2'd1, 0, 32'h00008001, 0, 1'b1, t_acc[4]);
      idle();
      for (int i = 1; i < 5; i++)
         check32("b2b_spacing", 32'(t_acc[i] - t_acc[i-1]), 32'(LAT * PERIOD));
      drain();

      // Reset during WAIT drops the store
      op("sw_50_zero", 1, 32'h50, 32'h0, 2'd2, 0, 32'h0, 0);
      issue("sw_50_abort", 1, 32'h50, 32'h12345678, 2'd2, 0, 32'h0, 0, 1'b0, t_acc[0]);
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check32("rst_mid_ready", 32'(req_ready), 32'd1);
      check32("rst_mid_valid", 32'(resp_valid), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      op("lw_50_after_rst", 0, 32'h50, 32'h0, 2'd2, 0, 32'h0, 0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
